// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, active window and measured
// line/frame totals from raw hsync/vsync, and tracks lock to the geometry.
//
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   hsync, vsync    raw sync inputs (polarity set by H/V_SYNC_POL)
//   x, y            coordinate inside the active window, 0 outside
//   active          pixel inside active window while locked
//   frame_start     one-cycle pulse on the first cycle of line 0
//   h_total         measured clocks per line (saturating)
//   v_total         measured lines per frame (saturating)
//   locked          geometry stable for a full frame
//   err             one-cycle pulse on lock loss or counter saturation
module vga_sync_decoder #(
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   H_OFFSET   = 144,
    parameter int   H_ACTIVE   = 640,
    parameter int   V_OFFSET   = 35,
    parameter int   V_ACTIVE   = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        active,
    output logic        frame_start,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic        locked,
    output logic        err
);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] CNT_PRE = 11'd2046;
    localparam logic [10:0] H_OFF11 = 11'(H_OFFSET);
    localparam logic [10:0] V_OFF11 = 11'(V_OFFSET);
    localparam logic [11:0] H_LO    = 12'(H_OFFSET);
    localparam logic [11:0] H_HI    = 12'(H_OFFSET + H_ACTIVE);
    localparam logic [11:0] V_LO    = 12'(V_OFFSET);
    localparam logic [11:0] V_HI    = 12'(V_OFFSET + V_ACTIVE);

    logic        hs_q, hs_q2, vs_q, vs_q2;
    logic        h_edge, v_edge;
    logic        v_pend, first_q;
    logic [10:0] h_cnt, v_cnt;
    logic [10:0] h_ref, v_ref;
    logic        ref_ok, bad;

    logic        v_hit, frame_edge;
    logic [10:0] h_tot_nxt, v_tot_nxt;
    logic        h_sat, v_sat, sat, h_ovf;
    logic        win, show;

    state_t      state, state_nxt;
    logic [10:0] h_ref_nxt, v_ref_nxt;
    logic        ref_ok_nxt, bad_nxt, err_nxt;
    logic        h_mis, bad_frame;

    // A vsync edge coinciding with the hsync edge is consumed by it.
    assign v_hit      = v_pend | v_edge;
    assign frame_edge = h_edge & v_hit;

    assign h_tot_nxt = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
    assign v_tot_nxt = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 11'd1;

    // Saturation events fire once, on the cycle a counter reaches max.
    assign h_sat = !h_edge && (h_cnt == CNT_PRE);
    assign v_sat = h_edge && !v_hit && (v_cnt == CNT_PRE);
    assign sat   = h_sat | v_sat;
    assign h_ovf = h_edge && (h_cnt == CNT_MAX);

    assign win = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI)
              && ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);

    assign locked = (state == LOCKED);
    assign show   = win && locked;

    always_comb begin
        state_nxt  = state;
        h_ref_nxt  = h_ref;
        v_ref_nxt  = v_ref;
        ref_ok_nxt = ref_ok;
        bad_nxt    = bad;
        err_nxt    = 1'b0;
        h_mis      = ref_ok && (h_tot_nxt != h_ref);
        bad_frame  = bad | sat | h_ovf | (h_edge & h_mis);
        unique case (state)
            SEARCH: begin
                if (frame_edge) begin
                    state_nxt  = MEASURE;
                    ref_ok_nxt = 1'b0;
                    bad_nxt    = 1'b0;
                end
            end
            MEASURE: begin
                err_nxt = sat;
                if (frame_edge) begin
                    if (!bad_frame) begin
                        state_nxt = LOCKED;
                        v_ref_nxt = v_tot_nxt;
                    end
                    ref_ok_nxt = 1'b0;
                    bad_nxt    = 1'b0;
                end else begin
                    bad_nxt = bad_frame;
                    // First line closed in this frame sets the reference.
                    if (h_edge && !ref_ok) begin
                        h_ref_nxt  = h_tot_nxt;
                        ref_ok_nxt = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (sat
                    || (h_edge && (h_tot_nxt != h_ref))
                    || (frame_edge && (v_tot_nxt != v_ref))) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q        <= 1'b0;
            hs_q2       <= 1'b0;
            vs_q        <= 1'b0;
            vs_q2       <= 1'b0;
            h_edge      <= 1'b0;
            v_edge      <= 1'b0;
            v_pend      <= 1'b0;
            first_q     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_total     <= '0;
            v_total     <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            state       <= SEARCH;
            h_ref       <= '0;
            v_ref       <= '0;
            ref_ok      <= 1'b0;
            bad         <= 1'b0;
        end else begin
            hs_q    <= hsync ~^ H_SYNC_POL;
            hs_q2   <= hs_q;
            vs_q    <= vsync ~^ V_SYNC_POL;
            vs_q2   <= vs_q;
            h_edge  <= hs_q & ~hs_q2;
            v_edge  <= vs_q & ~vs_q2;
            first_q <= frame_edge;

            if (h_edge) begin
                h_cnt   <= '0;
                h_total <= h_tot_nxt;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (h_edge) begin
                v_pend <= 1'b0;
            end else if (v_edge) begin
                v_pend <= 1'b1;
            end

            if (h_edge) begin
                if (v_hit) begin
                    v_total <= v_tot_nxt;
                    v_cnt   <= '0;
                end else begin
                    v_cnt <= v_tot_nxt;
                end
            end

            frame_start <= first_q && (h_cnt == '0) && (v_cnt == '0);
            active      <= show;
            x           <= show ? h_cnt - H_OFF11 : '0;
            y           <= show ? v_cnt - V_OFF11 : '0;
            err         <= err_nxt;
            state       <= state_nxt;
            h_ref       <= h_ref_nxt;
            v_ref       <= v_ref_nxt;
            ref_ok      <= ref_ok_nxt;
            bad         <= bad_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench with a pixel scoreboard for the
// sync decoder, using a reduced 28x15 raster to keep runs short.
module tb_vga_sync_decoder;

    localparam int HT  = 28;
    localparam int HSW = 4;
    localparam int HO  = 6;
    localparam int HA  = 16;
    localparam int VT  = 15;
    localparam int VSW = 2;
    localparam int VO  = 3;
    localparam int VA  = 10;

    typedef struct packed {
        logic        act;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic [10:0] x;
    logic [10:0] y;
    logic        active;
    logic        frame_start;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        locked;
    logic        err;

    vga_sync_decoder #(
        .H_SYNC_POL (1'b0),
        .V_SYNC_POL (1'b0),
        .H_OFFSET   (HO),
        .H_ACTIVE   (HA),
        .V_OFFSET   (VO),
        .V_ACTIVE   (VA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .x           (x),
        .y           (y),
        .active      (active),
        .frame_start (frame_start),
        .h_total     (h_total),
        .v_total     (v_total),
        .locked      (locked),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          err_seen = 0;
    int          act_seen = 0;
    int          fs_seen = 0;
    logic        lock_exp;
    logic        lk_b, lk_a;
    logic [10:0] s_x, s_y, s_ht, s_vt;
    logic        s_act, s_fs, s_lk, s_err;

    task automatic chk(input string tag, input logic [10:0] got,
                       input logic [10:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic sample();
        s_x   = x;
        s_y   = y;
        s_act = active;
        s_fs  = frame_start;
        s_ht  = h_total;
        s_vt  = v_total;
        s_lk  = locked;
        s_err = err;
        if (err) err_seen++;
        if (active) act_seen++;
        if (frame_start) fs_seen++;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_x"}, s_x, 11'd0);
        chk({p, "_y"}, s_y, 11'd0);
        chk({p, "_active"}, 11'(s_act), 11'd0);
        chk({p, "_fs"}, 11'(s_fs), 11'd0);
        chk({p, "_htotal"}, s_ht, 11'd0);
        chk({p, "_vtotal"}, s_vt, 11'd0);
        chk({p, "_locked"}, 11'(s_lk), 11'd0);
        chk({p, "_err"}, 11'(s_err), 11'd0);
    endtask

    // Pixel driven now shows up on the outputs four cycles later.
    task automatic tick(input logic r, input logic hs, input logic vs,
                        input exp_t e);
        exp_t want;
        @(posedge clk);
        #1;
        sample();
        if (sbq.size() == 4) begin
            want = sbq.pop_front();
            checks++;
            assert ({active, x, y, frame_start} === want) else begin
                errors++;
                $error("FAIL pix: got a=%0d x=%0d y=%0d fs=%0d want a=%0d x=%0d y=%0d fs=%0d",
                       active, x, y, frame_start,
                       want.act, want.x, want.y, want.fs);
            end
        end
        rst   = r;
        hsync = hs;
        vsync = vs;
        sbq.push_back(e);
    endtask

    function automatic exp_t pix(input int l, input int c, input logic lk);
        exp_t e;
        e = '0;
        if (lk && c >= HO && c < HO + HA && l >= VO && l < VO + VA) begin
            e.act = 1'b1;
            e.x   = 11'(c - HO);
            e.y   = 11'(l - VO);
        end
        e.fs = (l == 0) && (c == 0);
        return e;
    endfunction

    task automatic frame(input int short_line, input int rst_line,
                         input int rst_col);
        int len;
        for (int l = 0; l < VT; l++) begin
            len = (l == short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                logic r;
                r = (l == rst_line) && (c == rst_col);
                if (r) lock_exp = 1'b0;
                tick(r, (c < HSW) ? 1'b0 : 1'b1, (l < VSW) ? 1'b0 : 1'b1,
                     r ? exp_t'(0) : pix(l, c, lock_exp));
                if (r) begin
                    foreach (sbq[i]) sbq[i] = '0;
                end
                if (l == 0 && c == 2) lk_b = s_lk;
                if (l == 0 && c == 3) lk_a = s_lk;
                if (l == rst_line && c == rst_col + 1) chk_zero("midrst");
            end
            if (l == short_line) lock_exp = 1'b0;
        end
    endtask

    task automatic hold(input int n, input logic hs);
        repeat (n) tick(1'b0, hs, 1'b1, exp_t'(0));
    endtask

    int e0, a0, f0;

    initial begin
        rst      = 1'b1;
        hsync    = 1'b1;
        vsync    = 1'b1;
        lock_exp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        chk_zero("reset");

        // Frame 0 measures, frame 1 is the first locked frame.
        e0 = err_seen;
        frame(-1, -1, -1);
        chk("f0_locked", 11'(s_lk), 11'd0);
        lock_exp = 1'b1;
        a0 = act_seen;
        f0 = fs_seen;
        frame(-1, -1, -1);
        chk("f1_lk_before", 11'(lk_b), 11'd0);
        chk("f1_lk_after", 11'(lk_a), 11'd1);
        chk("f1_htotal", s_ht, 11'd28);
        chk("f1_vtotal", s_vt, 11'd15);
        chk("f1_active", 11'(act_seen - a0), 11'(HA * VA));
        chk("f1_fs", 11'(fs_seen - f0), 11'd1);

        a0 = act_seen;
        f0 = fs_seen;
        frame(-1, -1, -1);
        chk("f2_active", 11'(act_seen - a0), 11'(HA * VA));
        chk("f2_fs", 11'(fs_seen - f0), 11'd1);
        chk("f2_locked", 11'(s_lk), 11'd1);
        chk("f012_err", 11'(err_seen - e0), 11'd0);

        // One short line while locked.
        e0 = err_seen;
        a0 = act_seen;
        frame(7, -1, -1);
        chk("short_lk_start", 11'(lk_a), 11'd1);
        chk("short_err", 11'(err_seen - e0), 11'd1);
        chk("short_locked", 11'(s_lk), 11'd0);
        chk("short_active", 11'(act_seen - a0), 11'(HA * 5));

        e0 = err_seen;
        lock_exp = 1'b0;
        frame(-1, -1, -1);
        chk("reacq1_lk", 11'(lk_a), 11'd0);
        lock_exp = 1'b1;
        a0 = act_seen;
        frame(-1, -1, -1);
        chk("reacq2_lk_before", 11'(lk_b), 11'd0);
        chk("reacq2_lk_after", 11'(lk_a), 11'd1);
        chk("reacq2_active", 11'(act_seen - a0), 11'(HA * VA));
        chk("reacq_err", 11'(err_seen - e0), 11'd0);

        // hsync stuck asserted: counter saturates.
        e0 = err_seen;
        hold(3000, 1'b0);
        chk("sat_err", 11'(err_seen - e0), 11'd1);
        chk("sat_locked", 11'(s_lk), 11'd0);
        hold(10, 1'b1);
        hold(4, 1'b0);
        hold(2, 1'b1);
        chk("sat_htotal", s_ht, 11'd2047);
        hold(30, 1'b1);
        chk("sat_err_once", 11'(err_seen - e0), 11'd1);

        lock_exp = 1'b0;
        frame(-1, -1, -1);
        chk("post_sat_lk", 11'(lk_a), 11'd0);
        lock_exp = 1'b1;
        a0 = act_seen;
        frame(-1, -1, -1);
        chk("post_sat_lk_after", 11'(lk_a), 11'd1);
        chk("post_sat_vtotal", s_vt, 11'd15);
        chk("post_sat_active", 11'(act_seen - a0), 11'(HA * VA));

        // Reset pulse mid-frame inside the active window.
        a0 = act_seen;
        frame(-1, 5, 12);
        chk("midrst_active", 11'(act_seen - a0), 11'd35);
        lock_exp = 1'b0;
        frame(-1, -1, -1);
        chk("midrst_b1_lk", 11'(lk_a), 11'd0);
        lock_exp = 1'b1;
        a0 = act_seen;
        frame(-1, -1, -1);
        chk("midrst_b2_lk_before", 11'(lk_b), 11'd0);
        chk("midrst_b2_lk_after", 11'(lk_a), 11'd1);
        chk("midrst_b2_active", 11'(act_seen - a0), 11'(HA * VA));
        chk("midrst_htotal", s_ht, 11'd28);
        chk("midrst_vtotal", s_vt, 11'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
